// File: rtl/regfile_mp.sv
// Multi-port register file: one write port, two registered read ports with
// optional write/sweep bypass, optional hardwired-zero entry 0 and a soft-clear sweep.
module regfile_mp #(
  parameter int WIDTH    = 8,
  parameter int ADDR_W   = 2,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wEn,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  din,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  dout_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  dout_b,
  input  logic              clr,
  output logic              busy,
  output logic              wr_err,
  output logic              dbg_state
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [WIDTH-1:0]  r_dout_a, r_dout_b, w_rd_a, w_rd_b;
  logic              r_wr_err;
  logic              w_sweep, w_wr_commit;

  assign w_sweep     = (r_state == SWEEP);
  // Writes are only accepted in IDLE; entry 0 is read-only when hardwired to zero.
  assign w_wr_commit = !w_sweep && wEn && !((ZERO_REG != 0) && (waddr == '0));

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      IDLE: begin
        if (clr) begin
          w_state_nxt = SWEEP;
          w_ptr_nxt   = '0;
        end
      end
      SWEEP: begin
        w_ptr_nxt = r_ptr + 1'b1;
        if (r_ptr == LAST) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_rd_a = r_mem[raddr_a];
    if ((ZERO_REG != 0) && (raddr_a == '0))                     w_rd_a = '0;
    else if ((BYPASS != 0) && w_wr_commit && (waddr == raddr_a)) w_rd_a = din;
    else if ((BYPASS != 0) && w_sweep && (r_ptr == raddr_a))     w_rd_a = '0;
  end

  always_comb begin
    w_rd_b = r_mem[raddr_b];
    if ((ZERO_REG != 0) && (raddr_b == '0))                     w_rd_b = '0;
    else if ((BYPASS != 0) && w_wr_commit && (waddr == raddr_b)) w_rd_b = din;
    else if ((BYPASS != 0) && w_sweep && (r_ptr == raddr_b))     w_rd_b = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_dout_a <= '0;
      r_dout_b <= '0;
      r_wr_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_dout_a <= w_rd_a;
      r_dout_b <= w_rd_b;
      r_wr_err <= w_sweep && wEn;
    end
  end

  // A commit and a sweep never coincide: writes are refused while sweeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr_commit) r_mem[waddr] <= din;
      if (w_sweep)     r_mem[r_ptr] <= '0;
    end
  end

  assign dout_a    = r_dout_a;
  assign dout_b    = r_dout_b;
  assign busy      = w_sweep;
  assign wr_err    = r_wr_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (zero-reg+bypass, plain no-bypass) share
// stimulus and are compared against an array-based reference model.
module tb_regfile_mp;

  localparam int D = 4;

  logic       clk, reset, wEn, clr;
  logic [1:0] waddr, raddr_a, raddr_b;
  logic [7:0] din;
  logic [7:0] z_dout_a, z_dout_b, n_dout_a, n_dout_b;
  logic       z_busy, z_err, z_dbg, n_busy, n_err, n_dbg;

  regfile_mp #(.WIDTH(8), .ADDR_W(2), .ZERO_REG(1), .BYPASS(1)) dut_z (
    .clk(clk), .reset(reset), .wEn(wEn), .waddr(waddr), .din(din),
    .raddr_a(raddr_a), .dout_a(z_dout_a), .raddr_b(raddr_b), .dout_b(z_dout_b),
    .clr(clr), .busy(z_busy), .wr_err(z_err), .dbg_state(z_dbg));

  regfile_mp #(.WIDTH(8), .ADDR_W(2), .ZERO_REG(0), .BYPASS(0)) dut_n (
    .clk(clk), .reset(reset), .wEn(wEn), .waddr(waddr), .din(din),
    .raddr_a(raddr_a), .dout_a(n_dout_a), .raddr_b(raddr_b), .dout_b(n_dout_b),
    .clr(clr), .busy(n_busy), .wr_err(n_err), .dbg_state(n_dbg));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  // reference model: config 0 = zero-reg + bypass, config 1 = plain, no bypass
  logic [7:0] m_mem [2][D];
  logic [7:0] e_a [2];
  logic [7:0] e_b [2];
  logic       e_busy, e_err;
  int         remain;

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < D; i++) m_mem[c][i] = 8'h00;
      e_a[c] = 8'h00;
      e_b[c] = 8'h00;
    end
    e_busy = 1'b0;
    e_err  = 1'b0;
    remain = 0;
  endtask

  function automatic logic [7:0] model_read(int c, logic [1:0] ra, bit wr_ok, bit sweeping, int sa);
    if (c == 0 && ra == 2'd0) return 8'h00;
    if (c == 0 && wr_ok && waddr == ra) return din;
    if (c == 0 && sweeping && sa == int'(ra)) return 8'h00;
    return m_mem[c][ra];
  endfunction

  task automatic model_edge();
    bit sweeping, wr_ok;
    int sa;
    if (reset) begin
      model_reset();
      return;
    end
    sweeping = (remain > 0);
    sa = D - remain;
    for (int c = 0; c < 2; c++) begin
      wr_ok = !sweeping && wEn && !(c == 0 && waddr == 2'd0);
      e_a[c] = model_read(c, raddr_a, wr_ok, sweeping, sa);
      e_b[c] = model_read(c, raddr_b, wr_ok, sweeping, sa);
      if (wr_ok) m_mem[c][waddr] = din;
      if (sweeping) m_mem[c][sa] = 8'h00;
    end
    e_err = sweeping && wEn;
    if (sweeping) remain--;
    else if (clr) remain = D;
    e_busy = (remain > 0);
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic write(input logic [1:0] a, input logic [7:0] d);
    wEn = 1'b1; waddr = a; din = d;
    step();
    wEn = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; wEn = 1'b1; waddr = 2'd2; din = 8'h6E; clr = 1'b0;
    raddr_a = 2'd2; raddr_b = 2'd0;
    model_reset();
    step();
    step();
    reset = 1'b0; wEn = 1'b0;
    step();
    checks++; if (z_dout_a !== 8'h00) begin errors++; $display("FAIL reset_dout_a_z: got %h want 00", z_dout_a); end
    checks++; if (n_dout_a !== 8'h00) begin errors++; $display("FAIL reset_dout_a_n: got %h want 00", n_dout_a); end
    checks++; if (z_busy !== 1'b0 || n_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b/%b want 0", z_busy, n_busy); end
    checks++; if (z_err !== 1'b0 || n_err !== 1'b0) begin errors++; $display("FAIL reset_wr_err: got %b/%b want 0", z_err, n_err); end
  endtask

  task automatic test_bypass();
    raddr_a = 2'd2;
    write(2'd2, 8'h6E);
    checks++; if (z_dout_a !== 8'h6E) begin errors++; $display("FAIL bypass_a_z: got %h want 6e", z_dout_a); end
    checks++; if (n_dout_a !== e_a[1]) begin errors++; $display("FAIL nobypass_a_n: got %h want %h", n_dout_a, e_a[1]); end
    raddr_b = 2'd2;
    step();
    checks++; if (z_dout_b !== 8'h6E) begin errors++; $display("FAIL read_b_z: got %h want 6e", z_dout_b); end
    checks++; if (n_dout_b !== 8'h6E) begin errors++; $display("FAIL read_b_n: got %h want 6e", n_dout_b); end
  endtask

  task automatic test_zero_reg();
    raddr_a = 2'd0;
    write(2'd0, 8'hFF);
    checks++; if (z_dout_a !== 8'h00) begin errors++; $display("FAIL zero_reg_first: got %h want 00", z_dout_a); end
    checks++; if (z_err !== 1'b0) begin errors++; $display("FAIL zero_reg_err: got %b want 0", z_err); end
    step();
    checks++; if (z_dout_a !== 8'h00) begin errors++; $display("FAIL zero_reg_later: got %h want 00", z_dout_a); end
    checks++; if (n_dout_a !== 8'hFF) begin errors++; $display("FAIL plain_addr0: got %h want ff", n_dout_a); end
  endtask

  task automatic test_sweep();
    int cnt;
    write(2'd1, 8'h11); write(2'd2, 8'h22); write(2'd3, 8'h33);
    clr = 1'b1;
    step();
    clr = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20 && z_busy; i++) begin
      cnt++;
      wEn = (cnt == 2); waddr = 2'd1; din = 8'hAA;
      step();
      if (cnt == 2) begin
        checks++; if (z_err !== 1'b1 || n_err !== 1'b1) begin errors++; $display("FAIL drop_err_pulse: got %b/%b want 1", z_err, n_err); end
      end
      if (cnt == 3) begin
        checks++; if (z_err !== 1'b0 || n_err !== 1'b0) begin errors++; $display("FAIL drop_err_clear: got %b/%b want 0", z_err, n_err); end
      end
    end
    wEn = 1'b0;
    checks++; if (cnt != D) begin errors++; $display("FAIL busy_len: got %0d want %0d", cnt, D); end
    checks++; if (n_busy !== 1'b0) begin errors++; $display("FAIL busy_end_n: got %b want 0", n_busy); end
    for (int a = 0; a < D; a++) begin
      raddr_a = 2'(a); raddr_b = 2'(D - 1 - a);
      exp_q.push_back(8'h00); exp_q.push_back(8'h00);
      step();
      checks++; if (z_dout_a !== exp_q.pop_front()) begin errors++; $display("FAIL cleared_a[%0d]: got %h want 00", a, z_dout_a); end
      checks++; if (n_dout_b !== exp_q.pop_front()) begin errors++; $display("FAIL cleared_b[%0d]: got %h want 00", a, n_dout_b); end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int cnt;
    write(2'd1, 8'h11); write(2'd2, 8'h22); write(2'd3, 8'h33);
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    step();
    #2 reset = 1'b1;
    model_reset();
    #1;
    checks++; if (z_busy !== 1'b0 || n_busy !== 1'b0) begin errors++; $display("FAIL async_busy: got %b/%b want 0", z_busy, n_busy); end
    checks++; if (z_dout_a !== 8'h00 || n_dout_b !== 8'h00) begin errors++; $display("FAIL async_dout: got %h/%h want 00", z_dout_a, n_dout_b); end
    @(negedge clk);
    reset = 1'b0;
    for (int a = 1; a < D; a++) begin
      raddr_a = 2'(a); raddr_b = 2'(a);
      step();
      checks++; if (z_dout_a !== 8'h00 || n_dout_b !== 8'h00) begin errors++; $display("FAIL reset_entry[%0d]: got %h/%h want 00", a, z_dout_a, n_dout_b); end
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20 && z_busy; i++) begin
      cnt++;
      step();
    end
    checks++; if (cnt != D) begin errors++; $display("FAIL restart_len: got %0d want %0d", cnt, D); end
  endtask

  task automatic test_same_edge();
    logic [7:0] want;
    raddr_a = 2'd3; raddr_b = 2'd3;
    wEn = 1'b1; waddr = 2'd3; din = 8'h5A; clr = 1'b1;
    step();
    wEn = 1'b0; clr = 1'b0;
    checks++; if (z_dout_a !== 8'h5A || z_busy !== 1'b1) begin errors++; $display("FAIL same_edge_start: got %h busy %b want 5a busy 1", z_dout_a, z_busy); end
    for (int k = 1; k <= D; k++) begin
      step();
      want = (k < D) ? 8'h5A : 8'h00;
      checks++; if (z_dout_a !== want) begin errors++; $display("FAIL same_edge_k%0d: got %h want %h", k, z_dout_a, want); end
      checks++; if (n_dout_b !== e_b[1]) begin errors++; $display("FAIL same_edge_n_k%0d: got %h want %h", k, n_dout_b, e_b[1]); end
    end
    step();
    checks++; if (n_dout_a !== 8'h00 || z_busy !== 1'b0) begin errors++; $display("FAIL same_edge_end: got %h busy %b want 00 busy 0", n_dout_a, z_busy); end
  endtask

  task automatic test_random();
    logic [7:0] got_a [2];
    logic [7:0] got_b [2];
    logic       got_busy [2];
    logic       got_err  [2];
    logic       got_dbg  [2];
    for (int n = 0; n < 300; n++) begin
      wEn = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 11) == 0);
      waddr = 2'($urandom_range(0, 3));
      raddr_a = 2'($urandom_range(0, 3));
      raddr_b = 2'($urandom_range(0, 3));
      din = 8'($urandom);
      step();
      got_a[0] = z_dout_a; got_b[0] = z_dout_b; got_busy[0] = z_busy; got_err[0] = z_err; got_dbg[0] = z_dbg;
      got_a[1] = n_dout_a; got_b[1] = n_dout_b; got_busy[1] = n_busy; got_err[1] = n_err; got_dbg[1] = n_dbg;
      for (int c = 0; c < 2; c++) begin
        checks++; if (got_a[c] !== e_a[c]) begin errors++; $display("FAIL rand_a cfg%0d n%0d: got %h want %h", c, n, got_a[c], e_a[c]); end
        checks++; if (got_b[c] !== e_b[c]) begin errors++; $display("FAIL rand_b cfg%0d n%0d: got %h want %h", c, n, got_b[c], e_b[c]); end
        checks++; if (got_busy[c] !== e_busy || got_dbg[c] !== e_busy) begin errors++; $display("FAIL rand_busy cfg%0d n%0d: got %b/%b want %b", c, n, got_busy[c], got_dbg[c], e_busy); end
        checks++; if (got_err[c] !== e_err) begin errors++; $display("FAIL rand_err cfg%0d n%0d: got %b want %b", c, n, got_err[c], e_err); end
      end
    end
    wEn = 1'b0; clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_bypass();
    test_zero_reg();
    test_sweep();
    test_reset_mid_sweep();
    test_same_edge();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
